// File: rtl/sipo_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deserializer_if
// Description : Serial-in / parallel-out handshake bundle. The producer and
//               consumer side (master) drives the serial bits and the output
//               ready. The deserializer side (slave) returns the ready, the
//               word, its valid flag and the partial bit count.
// Revision    : 1.0 - initial release
// ============================================================================
interface sipo_deserializer_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH);

    logic             sin;
    logic             sin_valid;
    logic             sin_ready;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;
    logic [CW-1:0]    bit_cnt;

    modport master (
        output sin,
        output sin_valid,
        input  sin_ready,
        input  pout,
        input  pout_valid,
        output pout_ready,
        input  bit_cnt
    );

    modport slave (
        input  sin,
        input  sin_valid,
        output sin_ready,
        output pout,
        output pout_valid,
        input  pout_ready,
        output bit_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deserializer
// Description : Collects a one-bit stream into WIDTH-bit words and presents
//               them on a valid/ready port. The shift register doubles as a
//               one-word skid buffer, so the serial side keeps running at one
//               bit per cycle while the consumer stalls for up to one word.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    sipo_deserializer_if.slave   bus
);
    localparam int            CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    // Occupancy: ONE = a word on pout, TWO = a second word parked in sr.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_t;

    occ_t             state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             w_sin_ready;
    logic             w_pout_valid;
    logic             w_accept;
    logic             w_fire;
    logic             w_last;
    logic [CW-1:0]    w_pos;
    logic [WIDTH-1:0] w_word;

    // Ready depends only on registered state; no path from pout_ready.
    assign w_sin_ready  = (state_q != ST_TWO);
    assign w_pout_valid = (state_q != ST_EMPTY);
    assign w_accept     = bus.sin_valid & w_sin_ready;
    assign w_fire       = w_pout_valid & bus.pout_ready;
    assign w_last       = w_accept & (cnt_q == C_LAST);
    assign w_pos        = MSB_FIRST ? (C_LAST - cnt_q) : cnt_q;

    assign bus.sin_ready  = w_sin_ready;
    assign bus.pout_valid = w_pout_valid;
    assign bus.pout       = pout_q;
    assign bus.bit_cnt    = cnt_q;

    // Current shift register contents with the incoming bit merged in.
    always_comb begin
        w_word = sr_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (CW'(i) == w_pos) begin
                w_word[i] = bus.sin;
            end
        end
    end

    // Next-state: bit collection, word placement and drain of the skid word.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        pout_d  = pout_q;
        cnt_d   = cnt_q;

        if (w_accept) begin
            // Writing the merged word even on the last bit is harmless: every
            // position gets overwritten before the next word completes.
            sr_d  = w_word;
            cnt_d = w_last ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            ST_EMPTY: begin
                if (w_last) begin
                    pout_d  = w_word;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_last) begin
                    if (w_fire) begin
                        pout_d = w_word;
                    end else begin
                        state_d = ST_TWO;
                    end
                end else if (w_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_fire) begin
                    pout_d  = sr_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State register with synchronous reset discarding partial and parked words.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            sr_q    <= '0;
            pout_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            pout_q  <= pout_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_deserializer
// Description : Self-checking bench for sipo_deserializer. Directed vector
//               table, hand-written corner sequences and a randomized run
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer;
    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sipo_deserializer_if #(.WIDTH(WIDTH)) bus0 ();
    sipo_deserializer_if #(.WIDTH(WIDTH)) bus1 ();

    sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [WIDTH-1:0] e_pout,
                             input logic e_valid, input logic e_ready, input logic [CW-1:0] e_cnt);
        check({tag, ".pout"},       32'(bus0.pout),       32'(e_pout));
        check({tag, ".pout_valid"}, 32'(bus0.pout_valid), 32'(e_valid));
        check({tag, ".sin_ready"},  32'(bus0.sin_ready),  32'(e_ready));
        check({tag, ".bit_cnt"},    32'(bus0.bit_cnt),    32'(e_cnt));
    endtask

    // Inputs are driven at the falling edge; outputs are sampled at the next
    // falling edge, i.e. half a cycle after the rising edge that used them.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive0(input logic r, input logic s, input logic v, input logic pr);
        rst             = r;
        bus0.sin        = s;
        bus0.sin_valid  = v;
        bus0.pout_ready = pr;
    endtask

    // ---------------- reference model (word queue) ----------------
    int               m_bits[$];
    logic [WIDTH-1:0] m_words[$];
    logic [WIDTH-1:0] m_shown;

    function automatic void model_step(input logic r, input logic s, input logic v, input logic pr);
        logic             acc;
        logic             fire;
        logic [WIDTH-1:0] w;
        if (r) begin
            m_bits.delete();
            m_words.delete();
            m_shown = '0;
            return;
        end
        acc  = v && (m_words.size() < 2);
        fire = (m_words.size() > 0) && pr;
        if (fire) void'(m_words.pop_front());
        if (acc) begin
            m_bits.push_back(int'(s));
            if (m_bits.size() == WIDTH) begin
                w = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (m_bits[i] != 0) w[i] = 1'b1;
                end
                m_words.push_back(w);
                m_bits.delete();
            end
        end
        if (m_words.size() > 0) m_shown = m_words[0];
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic             r;
        logic             s;
        logic             v;
        logic             pr;
        logic [WIDTH-1:0] e_pout;
        logic             e_valid;
        logic             e_ready;
        logic [CW-1:0]    e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic s, input logic v, input logic pr,
                                input logic [WIDTH-1:0] ep, input logic ev, input logic er,
                                input logic [CW-1:0] ec);
        vec_t t;
        t.r = r; t.s = s; t.v = v; t.pr = pr;
        t.e_pout = ep; t.e_valid = ev; t.e_ready = er; t.e_cnt = ec;
        vecs.push_back(t);
    endfunction

    initial begin
        logic [WIDTH-1:0] pat;
        logic [WIDTH-1:0] words3 [3];
        int               stall_left;
        logic             rr, rs, rv, rp;

        // LSB-first basic: 1,0,1,1 -> 4'b1101, valid for one cycle
        add(0, 1, 1, 1, 4'h0, 0, 1, 2'd1);
        add(0, 0, 1, 1, 4'h0, 0, 1, 2'd2);
        add(0, 1, 1, 1, 4'h0, 0, 1, 2'd3);
        add(0, 1, 1, 1, 4'hD, 1, 1, 2'd0);
        add(0, 0, 0, 1, 4'hD, 0, 1, 2'd0);
        add(0, 0, 0, 1, 4'hD, 0, 1, 2'd0);
        // Backpressure: 4'h5 then 4'h9 with consumer stalled
        add(0, 1, 1, 0, 4'hD, 0, 1, 2'd1);
        add(0, 0, 1, 0, 4'hD, 0, 1, 2'd2);
        add(0, 1, 1, 0, 4'hD, 0, 1, 2'd3);
        add(0, 0, 1, 0, 4'h5, 1, 1, 2'd0);
        add(0, 1, 1, 0, 4'h5, 1, 1, 2'd1);
        add(0, 0, 1, 0, 4'h5, 1, 1, 2'd2);
        add(0, 0, 1, 0, 4'h5, 1, 1, 2'd3);
        add(0, 1, 1, 0, 4'h5, 1, 0, 2'd0);
        add(0, 1, 1, 0, 4'h5, 1, 0, 2'd0);
        add(0, 0, 0, 1, 4'h9, 1, 1, 2'd0);
        add(0, 0, 0, 1, 4'h9, 0, 1, 2'd0);

        drive0(1'b1, 1'b0, 1'b0, 1'b0);
        bus1.sin        = 1'b0;
        bus1.sin_valid  = 1'b0;
        bus1.pout_ready = 1'b1;
        @(negedge clk);

        // ---- reset with random serial activity ----
        for (int i = 0; i < 2; i++) begin
            drive0(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end
        check_all("reset", 4'h0, 1'b0, 1'b1, 2'd0);

        // ---- table ----
        for (int i = 0; i < vecs.size(); i++) begin
            drive0(vecs[i].r, vecs[i].s, vecs[i].v, vecs[i].pr);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_pout, vecs[i].e_valid,
                      vecs[i].e_ready, vecs[i].e_cnt);
        end

        // ---- back-to-back: A, 3, F with no bubbles ----
        words3[0] = 4'hA; words3[1] = 4'h3; words3[2] = 4'hF;
        for (int i = 0; i < 12; i++) begin
            pat = words3[i / 4];
            drive0(1'b0, pat[i % 4], 1'b1, 1'b1);
            tick();
            check($sformatf("b2b%0d.valid", i), 32'(bus0.pout_valid), 32'((i % 4) == 3));
            check($sformatf("b2b%0d.ready", i), 32'(bus0.sin_ready), 32'd1);
            if ((i % 4) == 3) check($sformatf("b2b%0d.pout", i), 32'(bus0.pout), 32'(pat));
        end
        drive0(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("b2b.drain", 32'(bus0.pout_valid), 32'd0);

        // ---- gaps: sin_valid toggles, garbage on idle cycles ----
        pat = 4'h6;
        for (int i = 0; i < 8; i++) begin
            if ((i % 2) == 0) drive0(1'b0, pat[i / 2], 1'b1, 1'b1);
            else              drive0(1'b0, 1'($urandom), 1'b0, 1'b1);
            tick();
            check($sformatf("gap%0d.cnt", i), 32'(bus0.bit_cnt), 32'((i / 2 + 1) % 4));
            check($sformatf("gap%0d.valid", i), 32'(bus0.pout_valid), 32'(i == 6));
            if (i == 6) check("gap.pout", 32'(bus0.pout), 32'h6);
        end

        // ---- reset mid-word ----
        drive0(1'b0, 1'b1, 1'b1, 1'b1); tick();
        drive0(1'b0, 1'b1, 1'b1, 1'b1); tick();
        check("mid.cnt_before", 32'(bus0.bit_cnt), 32'd2);
        drive0(1'b1, 1'b1, 1'b1, 1'b1); tick();
        check_all("mid.rst", 4'h0, 1'b0, 1'b1, 2'd0);
        pat = 4'h4;
        for (int i = 0; i < 4; i++) begin
            drive0(1'b0, pat[i], 1'b1, 1'b1);
            tick();
        end
        check_all("mid.word", 4'h4, 1'b1, 1'b1, 2'd0);
        drive0(1'b0, 1'b0, 1'b0, 1'b1); tick();

        // ---- MSB-first instance: 1,0,0,0 -> 4'b1000 ----
        pat = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            bus1.sin       = pat[i];
            bus1.sin_valid = 1'b1;
            tick();
        end
        bus1.sin_valid = 1'b0;
        check("msb.pout",  32'(bus1.pout),       32'h8);
        check("msb.valid", 32'(bus1.pout_valid), 32'd1);
        check("msb.cnt",   32'(bus1.bit_cnt),    32'd0);
        tick();
        check("msb.drain", 32'(bus1.pout_valid), 32'd0);

        // ---- randomized run against the reference model ----
        drive0(1'b1, 1'b0, 1'b0, 1'b0);
        model_step(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        stall_left = 0;
        for (int i = 0; i < 800; i++) begin
            rr = ($urandom_range(0, 149) == 0);
            rs = 1'($urandom);
            rv = ($urandom_range(0, 9) < 8);
            if (stall_left > 0) begin
                rp = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 15) == 0) begin
                rp = 1'b0;
                stall_left = int'($urandom_range(2, 10));
            end else begin
                rp = ($urandom_range(0, 3) != 0);
            end
            drive0(rr, rs, rv, rp);
            model_step(rr, rs, rv, rp);
            tick();
            check_all($sformatf("rnd%0d", i), m_shown, 1'(m_words.size() > 0),
                      1'(m_words.size() < 2), CW'(m_bits.size()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
